// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with programmable step, wrap or saturate,
// and one-cycle carry/borrow/err pulses for cascading digit counters.
module mod_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             borrow,
  output logic             tc,
  output logic             err
);

  if (MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_modulus
    $error("mod_updown_counter: MODULUS out of range 2..2**WIDTH");
  end

  localparam logic [WIDTH:0]   MODW = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP  = WIDTH'(MODULUS - 1);

  logic [WIDTH:0]   cx;
  logic [WIDTH:0]   sx;
  logic [WIDTH:0]   lx;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] nxt;
  logic             c_nxt;
  logic             b_nxt;
  logic             e_nxt;

  // One extra bit so sum never truncates at 2**WIDTH.
  assign cx  = {1'b0, count};
  assign sx  = {1'b0, step};
  assign lx  = {1'b0, load_val};
  assign sum = cx + sx;

  always_comb begin
    nxt   = count;
    c_nxt = 1'b0;
    b_nxt = 1'b0;
    e_nxt = 1'b0;
    if (load) begin
      if (lx >= MODW) e_nxt = 1'b1;
      else            nxt   = load_val;
    end else if (en) begin
      if (sx >= MODW) begin
        e_nxt = 1'b1;
      end else if (up) begin
        if (sum >= MODW) begin
          c_nxt = 1'b1;
          nxt   = (SATURATE != 0) ? TOP
                                  : WIDTH'(sum - MODW);
        end else begin
          nxt = sum[WIDTH-1:0];
        end
      end else begin
        if (sx > cx) begin
          b_nxt = 1'b1;
          nxt   = (SATURATE != 0) ? '0
                                  : WIDTH'(cx + MODW - sx);
        end else begin
          nxt = count - step;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      carry  <= 1'b0;
      borrow <= 1'b0;
      err    <= 1'b0;
    end else begin
      count  <= nxt;
      carry  <= c_nxt;
      borrow <= b_nxt;
      err    <= e_nxt;
    end
  end

  assign tc = up ? (count == TOP) : (count == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench: three counter configurations (wrap/10, saturate/10, wrap/16)
// share one stimulus stream and are checked against an integer model.
module tb_mod_updown_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] step;
  logic [3:0] cnt [3];
  logic       cy  [3];
  logic       bw  [3];
  logic       tcv [3];
  logic       er  [3];

  int n_chk;
  int n_err;

  int mods [3] = '{10, 10, 16};
  int sats [3] = '{0, 1, 0};
  int m_cnt [3];
  int m_c [3];
  int m_b [3];
  int m_e [3];

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .step(step), .count(cnt[0]),
    .carry(cy[0]), .borrow(bw[0]), .tc(tcv[0]), .err(er[0]));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .step(step), .count(cnt[1]),
    .carry(cy[1]), .borrow(bw[1]), .tc(tcv[1]), .err(er[1]));

  mod_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .step(step), .count(cnt[2]),
    .carry(cy[2]), .borrow(bw[2]), .tc(tcv[2]), .err(er[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0;
      m_c[i] = 0;
      m_b[i] = 0;
      m_e[i] = 0;
    end
  endtask

  // Arithmetic on plain integers straight from the counting rules.
  task automatic model_edge();
    int s;
    int d;
    for (int i = 0; i < 3; i++) begin
      m_c[i] = 0;
      m_b[i] = 0;
      m_e[i] = 0;
      if (load) begin
        if (int'(load_val) >= mods[i]) m_e[i] = 1;
        else m_cnt[i] = int'(load_val);
      end else if (en) begin
        if (int'(step) >= mods[i]) begin
          m_e[i] = 1;
        end else if (up) begin
          s = m_cnt[i] + int'(step);
          if (s >= mods[i]) begin
            m_c[i] = 1;
            m_cnt[i] = sats[i] != 0 ? mods[i] - 1 : s - mods[i];
          end else begin
            m_cnt[i] = s;
          end
        end else begin
          d = m_cnt[i] - int'(step);
          if (d < 0) begin
            m_b[i] = 1;
            m_cnt[i] = sats[i] != 0 ? 0 : d + mods[i];
          end else begin
            m_cnt[i] = d;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    int t;
    for (int i = 0; i < 3; i++) begin
      t = up ? int'(m_cnt[i] == mods[i] - 1) : int'(m_cnt[i] == 0);
      chk($sformatf("%s.count%0d", tag, i), 32'(cnt[i]), m_cnt[i]);
      chk($sformatf("%s.carry%0d", tag, i), 32'(cy[i]), m_c[i]);
      chk($sformatf("%s.borrow%0d", tag, i), 32'(bw[i]), m_b[i]);
      chk($sformatf("%s.err%0d", tag, i), 32'(er[i]), m_e[i]);
      chk($sformatf("%s.tc%0d", tag, i), 32'(tcv[i]), t);
    end
  endtask

  task automatic cyc(input string tag, input logic e, input logic u,
                     input logic l, input logic [3:0] lv,
                     input logic [3:0] st);
    en = e;
    up = u;
    load = l;
    load_val = lv;
    step = st;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    en = 1'b0;
    up = 1'b1;
    load = 1'b0;
    load_val = '0;
    step = '0;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b0;

    // Async reset between edges, with flags raised beforehand.
    cyc("pre_rst_ld", 0, 1, 1, 4'd7, 4'd0);
    cyc("pre_rst_en", 1, 1, 0, 4'd0, 4'd14);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst = 1'b0;

    // Up wrap through MODULUS-1.
    cyc("t2_ld", 0, 1, 1, 4'd8, 4'd0);
    cyc("t2_a", 1, 1, 0, 4'd0, 4'd1);
    chk("t2_w_cnt9", 32'(cnt[0]), 9);
    chk("t2_w_tc9", 32'(tcv[0]), 1);
    cyc("t2_b", 1, 1, 0, 4'd0, 4'd1);
    chk("t2_w_cnt0", 32'(cnt[0]), 0);
    chk("t2_w_carry", 32'(cy[0]), 1);
    cyc("t2_c", 1, 1, 0, 4'd0, 4'd1);
    chk("t2_w_cnt1", 32'(cnt[0]), 1);
    chk("t2_w_carry_off", 32'(cy[0]), 0);

    // Down wrap, then exact reach of zero.
    cyc("t3_ld", 0, 0, 1, 4'd2, 4'd0);
    cyc("t3_a", 1, 0, 0, 4'd0, 4'd3);
    chk("t3_w_cnt9", 32'(cnt[0]), 9);
    chk("t3_w_borrow", 32'(bw[0]), 1);
    cyc("t3_b", 1, 0, 0, 4'd0, 4'd9);
    chk("t3_w_cnt0", 32'(cnt[0]), 0);
    chk("t3_w_tc", 32'(tcv[0]), 1);

    // Saturation and repeated carry at the limit.
    cyc("t4_ld", 0, 1, 1, 4'd8, 4'd0);
    cyc("t4_a", 1, 1, 0, 4'd0, 4'd5);
    chk("t4_s_cnt9", 32'(cnt[1]), 9);
    chk("t4_s_carry", 32'(cy[1]), 1);
    cyc("t4_b", 1, 1, 0, 4'd0, 4'd5);
    chk("t4_s_carry2", 32'(cy[1]), 1);
    cyc("t4_c", 1, 0, 0, 4'd0, 4'd15);
    chk("t4_s_err", 32'(er[1]), 1);
    chk("t4_s_hold9", 32'(cnt[1]), 9);

    // Load priority, illegal load, idle hold.
    cyc("t5_a", 1, 1, 1, 4'd4, 4'd3);
    chk("t5_w_cnt4", 32'(cnt[0]), 4);
    cyc("t5_b", 1, 1, 1, 4'd12, 4'd3);
    chk("t5_w_err", 32'(er[0]), 1);
    for (int k = 0; k < 5; k++) cyc("t5_idle", 0, 1, 0, 4'd0, 4'd1);
    cyc("t5_step0", 1, 0, 0, 4'd0, 4'd0);

    // Binary wrap in the MODULUS=16 instance.
    cyc("t6_ld", 0, 1, 1, 4'd15, 4'd0);
    cyc("t6_a", 1, 1, 0, 4'd0, 4'd1);
    chk("t6_b_cnt0", 32'(cnt[2]), 0);
    chk("t6_b_carry", 32'(cy[2]), 1);
    cyc("t6_b", 1, 0, 0, 4'd0, 4'd1);
    chk("t6_b_cnt15", 32'(cnt[2]), 15);
    chk("t6_b_borrow", 32'(bw[2]), 1);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      cyc("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom),
          1'($urandom_range(0, 7) == 0), 4'($urandom), 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
